// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states and the 3-bit ALU operation codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  // Same encoding as the classic alucontrol field of the single-cycle core.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  function automatic logic funct_valid(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic op_valid(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_RTYPE:                                    return funct_valid(f);
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 and indices >= NREG read as zero and ignore writes.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [4:0]    i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [4:0]    i_raddr1,
  input  logic [4:0]    i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && i_waddr != 5'd0 && int'(i_waddr) < NREG) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != 5'd0 && int'(i_raddr1) < NREG) o_rdata1 = r_regs[i_raddr1];
    if (i_raddr2 != 5'd0 && int'(i_raddr2) < NREG) o_rdata2 = r_regs[i_raddr2];
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: one shared ALU, one req/ack memory port for
// both instructions and data, and a FETCH/DECODE/EXEC/MEM/WB control FSM.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc_out,
  output logic          retire,
  output logic          halted,
  output logic          illegal
);

  localparam int JW = (AW < 26) ? AW : 26;

  state_t        r_state, w_next;
  logic [AW-1:0] r_pc, w_jtarget;
  logic [31:0]   r_ir;
  logic [DW-1:0] r_mdr, r_a, r_b, r_aluout;
  logic          r_halted, r_illegal;

  logic [5:0]    w_op, w_funct;
  logic [DW-1:0] w_imm, w_rdA, w_rdB, w_alub, w_alures, w_rfwdata;
  logic [4:0]    w_rfwaddr;
  logic          w_req, w_we, w_retire, w_rfwe;
  alu_op_t       w_aluop;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_imm   = {{(DW-16){r_ir[15]}}, r_ir[15:0]};

  always_comb begin
    w_jtarget         = r_pc;
    w_jtarget[JW-1:0] = r_ir[JW-1:0];
  end

  mc_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_rfwe),
    .i_waddr  (w_rfwaddr),
    .i_wdata  (w_rfwdata),
    .i_raddr1 (r_ir[25:21]),
    .i_raddr2 (r_ir[20:16]),
    .o_rdata1 (w_rdA),
    .o_rdata2 (w_rdB)
  );

  // Only R-type uses funct; every other ALU use is an address/immediate add.
  always_comb begin
    w_aluop  = (w_op == OP_RTYPE) ? funct_to_alu(w_funct) : ALU_ADD;
    w_alub   = (w_op == OP_RTYPE) ? r_b : w_imm;
    w_alures = r_a + w_alub;
    case (w_aluop)
      ALU_SUB: w_alures = r_a - w_alub;
      ALU_AND: w_alures = r_a & w_alub;
      ALU_OR:  w_alures = r_a | w_alub;
      ALU_SLT: w_alures = {{(DW-1){1'b0}}, ($signed(r_a) < $signed(w_alub))};
      default: w_alures = r_a + w_alub;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_retire  = 1'b0;
    w_rfwe    = 1'b0;
    w_rfwaddr = r_ir[20:16];
    w_rfwdata = r_aluout;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        if (mem_ack) w_next = DECODE;
      end
      DECODE: begin
        case (w_op)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_next = EXEC;
          OP_RTYPE: w_next = funct_valid(w_funct) ? EXEC : HALT;
          OP_J:     begin w_retire = 1'b1; w_next = FETCH; end
          OP_HALT:  begin w_retire = 1'b1; w_next = HALT; end
          default:  w_next = HALT;
        endcase
      end
      EXEC: begin
        case (w_op)
          OP_RTYPE, OP_ADDI: w_next = WB;
          OP_LW, OP_SW:      w_next = MEM;
          default:           begin w_retire = 1'b1; w_next = FETCH; end
        endcase
      end
      MEM: begin
        w_req = 1'b1;
        w_we  = (w_op == OP_SW);
        if (mem_ack) begin
          w_retire = (w_op == OP_SW);
          w_next   = (w_op == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        w_retire = 1'b1;
        w_rfwe   = 1'b1;
        w_next   = FETCH;
        if (w_op == OP_RTYPE) w_rfwaddr = r_ir[15:11];
        if (w_op == OP_LW)    w_rfwdata = r_mdr;
      end
      default: w_next = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (mem_ack) begin
          r_ir <= mem_rdata[31:0];
          r_pc <= r_pc + AW'(1);
        end
        DECODE: begin
          r_a      <= w_rdA;
          r_b      <= w_rdB;
          r_aluout <= DW'(r_pc) + w_imm;
          if (w_op == OP_J)    r_pc <= w_jtarget;
          if (w_next == HALT)  r_halted <= 1'b1;
          if (!op_valid(w_op, w_funct)) r_illegal <= 1'b1;
        end
        EXEC: begin
          if (w_op == OP_BEQ) begin
            if (r_a == r_b) r_pc <= r_aluout[AW-1:0];
          end else begin
            r_aluout <= w_alures;
          end
        end
        MEM: if (mem_ack && w_op != OP_SW) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Gating with rst drops a pending request the instant reset asserts.
  assign mem_req   = w_req & rst;
  assign mem_we    = w_we & rst;
  assign mem_addr  = (r_state == FETCH) ? r_pc : r_aluout[AW-1:0];
  assign mem_wdata = r_b;
  assign pc_out    = r_pc;
  assign retire    = w_retire;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: a table of ALU programs plus
// directed sequences for wait states, branches, illegal ops and reset.
module tb_multicycle_datapath;
  import mc_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          retire, halted, illegal;

  multicycle_datapath #(.DW(DW), .AW(AW), .NREG(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_out    (pc_out),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model with a programmable number of wait cycles per transfer
  logic [31:0] mem [256];
  int          waitCycles = 0;
  int          pendCnt;
  int          wrCnt, w10Cnt;
  logic [31:0] w10Data;

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack   = mem_req && (pendCnt == waitCycles);

  always @(posedge clk or negedge rst) begin
    if (!rst) pendCnt <= 0;
    else if (mem_req && mem_ack) pendCnt <= 0;
    else if (mem_req) pendCnt <= pendCnt + 1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrCnt = 0; w10Cnt = 0; w10Data = '0;
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[7:0]] = mem_wdata;
      wrCnt++;
      if (mem_addr == 10) begin w10Cnt++; w10Data = mem_wdata; end
    end
  end

  // Observation counters, sampled mid-cycle
  int          cycleCnt;
  int          retireCnt, firstRetire, reqAfterHalt, weCyc10, stabBad = 0;
  int          fetchAddr[$];
  int          fetchCyc[$];
  logic        waiting = 1'b0;
  logic [31:0] heldAddr, heldData;
  logic        heldWe;

  always @(posedge clk or negedge rst) begin
    if (!rst) cycleCnt = 0;
    else      cycleCnt++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      retireCnt = 0; firstRetire = 0; reqAfterHalt = 0; weCyc10 = 0;
      fetchAddr.delete(); fetchCyc.delete();
      waiting = 1'b0;
    end else begin
      if (retire) begin
        retireCnt++;
        if (firstRetire == 0) firstRetire = cycleCnt + 1;
      end
      if (halted && mem_req) reqAfterHalt++;
      if (mem_req && mem_we && mem_addr == 10) weCyc10++;
      if (mem_req && mem_ack && !mem_we) begin
        fetchAddr.push_back(int'(mem_addr));
        fetchCyc.push_back(cycleCnt);
      end
      if (waiting && (!mem_req || mem_addr != heldAddr || mem_we != heldWe ||
                      mem_wdata != heldData)) stabBad++;
      waiting  = mem_req && !mem_ack;
      heldAddr = mem_addr;
      heldWe   = mem_we;
      heldData = mem_wdata;
    end
  end

  function automatic logic [31:0] encR(input int rs, input int rt, input int rd,
                                       input logic [5:0] f);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rs,
                                       input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reset held across two edges; memory is wiped while the core is quiet
  task automatic holdReset();
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    waitCycles = 0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitHalt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  typedef struct packed {
    logic [15:0] immA;
    logic [15:0] immB;
    logic [5:0]  funct;
    logic [31:0] expVal;
  } vec_t;

  vec_t vecs[8];

  task automatic applyStimulus(input int idx);
    holdReset();
    mem[0] = encI(OP_ADDI, 0, 1, vecs[idx].immA);
    mem[1] = encI(OP_ADDI, 0, 2, vecs[idx].immB);
    mem[2] = encR(1, 2, 3, vecs[idx].funct);
    mem[3] = encI(OP_SW, 0, 3, 16'd100);
    mem[4] = encJ(OP_HALT, 26'd0);
    releaseReset();
    waitHalt(100);
    checkOutput($sformatf("alu%0d_f%02h", idx, vecs[idx].funct), mem[100],
                vecs[idx].expVal);
    checkOutput($sformatf("alu%0d_retires", idx), retireCnt, 32'd5);
  endtask

  initial begin
    vecs[0] = '{16'd5,    16'hFFFD, F_ADD, 32'd2};
    vecs[1] = '{16'd5,    16'hFFFD, F_SUB, 32'd8};
    vecs[2] = '{16'h00F0, 16'h0FF0, F_AND, 32'h0000_00F0};
    vecs[3] = '{16'h00F0, 16'h0F0F, F_OR,  32'h0000_0FFF};
    vecs[4] = '{16'hFFFF, 16'd1,    F_SLT, 32'd1};
    vecs[5] = '{16'd1,    16'hFFFF, F_SLT, 32'd0};
    vecs[6] = '{16'd0,    16'd1,    F_SUB, 32'hFFFF_FFFF};
    vecs[7] = '{16'hFFFF, 16'h8000, F_AND, 32'hFFFF_8000};

    // Reset state and the basic addi/addi/add/halt program
    holdReset();
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_retire",  {31'b0, retire},  32'd0);
    checkOutput("rst_pc",      pc_out,           32'd0);
    mem[0] = encI(OP_ADDI, 0, 1, 16'd5);
    mem[1] = encI(OP_ADDI, 0, 2, 16'hFFFD);
    mem[2] = encR(1, 2, 3, F_ADD);
    mem[3] = encJ(OP_HALT, 26'd0);
    releaseReset();
    step(12);
    checkOutput("basic_not_halted_12", {31'b0, halted}, 32'd0);
    checkOutput("basic_retires_12",    retireCnt,       32'd3);
    step(3);
    checkOutput("basic_halted_15",  {31'b0, halted},  32'd1);
    checkOutput("basic_retires_15", retireCnt,        32'd4);
    checkOutput("basic_illegal",    {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_clears_halted", {31'b0, halted}, 32'd0);
    checkOutput("rst_clears_pc",     pc_out,          32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // lw with three wait cycles on every transfer
    holdReset();
    waitCycles = 3;
    mem[0] = encI(OP_LW, 0, 4, 16'd2);
    mem[1] = encJ(OP_J, 26'd3);
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = encI(OP_SW, 0, 4, 16'd20);
    mem[4] = encJ(OP_HALT, 26'd0);
    releaseReset();
    waitHalt(300);
    checkOutput("lw_wait_data",   mem[20],     32'hDEAD_BEEF);
    checkOutput("lw_wait_cycles", firstRetire, 32'd11);

    // sw then lw through the same address
    holdReset();
    mem[0] = encI(OP_ADDI, 0, 1, 16'd7);
    mem[1] = encI(OP_SW, 0, 1, 16'd10);
    mem[2] = encI(OP_LW, 0, 5, 16'd10);
    mem[3] = encI(OP_SW, 0, 5, 16'd11);
    mem[4] = encJ(OP_HALT, 26'd0);
    releaseReset();
    waitHalt(100);
    checkOutput("sw_writes_10", w10Cnt,  32'd1);
    checkOutput("sw_wdata_10",  w10Data, 32'd7);
    checkOutput("sw_we_cycles", weCyc10, 32'd1);
    checkOutput("lw_after_sw",  mem[11], 32'd7);

    // beq r0,r0,-1 at PC 4 loops on itself every 3 cycles
    holdReset();
    mem[0] = encJ(OP_J, 26'd4);
    mem[4] = encI(OP_BEQ, 0, 0, 16'hFFFF);
    releaseReset();
    step(14);
    checkOutput("beq_loop_fetches", fetchAddr.size() >= 4 ? 32'd1 : 32'd0, 32'd1);
    if (fetchAddr.size() >= 4) begin
      checkOutput("beq_loop_pc1", fetchAddr[1], 32'd4);
      checkOutput("beq_loop_pc3", fetchAddr[3], 32'd4);
      checkOutput("beq_loop_period", fetchCyc[3] - fetchCyc[2], 32'd3);
    end

    // beq not taken falls through to PC+1
    holdReset();
    mem[0] = encI(OP_ADDI, 0, 1, 16'd1);
    mem[1] = encJ(OP_J, 26'd4);
    mem[4] = encI(OP_BEQ, 1, 0, 16'd3);
    mem[5] = encJ(OP_HALT, 26'd0);
    mem[8] = encJ(OP_HALT, 26'd0);
    releaseReset();
    waitHalt(100);
    checkOutput("beq_nt_next", fetchAddr.size() >= 4 ? fetchAddr[3] : -1, 32'd5);

    // j 0x20 lands at 0x20; the word after j would trap if executed
    holdReset();
    mem[0]    = encJ(OP_J, 26'h20);
    mem[1]    = {6'h3E, 26'd0};
    mem[8'h20] = encJ(OP_HALT, 26'd0);
    releaseReset();
    waitHalt(100);
    checkOutput("j_target",  fetchAddr.size() >= 2 ? fetchAddr[1] : -1, 32'h20);
    checkOutput("j_illegal", {31'b0, illegal}, 32'd0);

    // Undefined opcode
    holdReset();
    mem[0] = {6'h3E, 26'd0};
    releaseReset();
    step(10);
    checkOutput("illop_illegal", {31'b0, illegal}, 32'd1);
    checkOutput("illop_halted",  {31'b0, halted},  32'd1);
    checkOutput("illop_retires", retireCnt,        32'd0);
    checkOutput("illop_no_req",  reqAfterHalt,     32'd0);

    // Undefined R-type funct after one good instruction
    holdReset();
    mem[0] = encI(OP_ADDI, 0, 1, 16'd3);
    mem[1] = encR(1, 1, 3, 6'h01);
    releaseReset();
    step(15);
    checkOutput("illfn_illegal", {31'b0, illegal}, 32'd1);
    checkOutput("illfn_retires", retireCnt,        32'd1);
    checkOutput("illfn_no_req",  reqAfterHalt,     32'd0);

    // Reset during a waited fetch, then r0 stays zero
    holdReset();
    waitCycles = 5;
    mem[0]  = encI(OP_ADDI, 0, 0, 16'd9);
    mem[1]  = encI(OP_SW, 0, 0, 16'd30);
    mem[2]  = encJ(OP_HALT, 26'd0);
    mem[30] = 32'h0000_1234;
    releaseReset();
    step(2);
    checkOutput("midrst_req_before", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_req_dropped", {31'b0, mem_req}, 32'd0);
    waitCycles = 0;
    step(2);
    releaseReset();
    waitHalt(100);
    checkOutput("midrst_first_fetch", fetchAddr.size() >= 1 ? fetchAddr[0] : -1, 32'd0);
    checkOutput("r0_stays_zero",      mem[30], 32'd0);
    checkOutput("midrst_writes",      wrCnt,   32'd1);

    checkOutput("handshake_stable", stabBad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
